zone_hyst_ctrl: RTL and testbench
=================================

Name: zone_hyst_ctrl

Overview:
Sequencing controller around the 3-zone hysteresis classifier: LOW=2'b10, MID=2'b00, HIGH=2'b01 on a 5-bit sensor value.
- Adds runtime-programmable thresholds, dwell qualification (N consecutive agreeing samples) and a minimum hold time after each zone change.
- Drives heater/cooler enables from the committed zone.
- Sits between the sensor sample stream and the actuator drivers.

Parameters:
W, 5, sample and threshold width
DWELL, 2, consecutive qualifying samples needed before a zone change (1..15)
MIN_HOLD, 4, clock cycles after a commit during which no further commit is allowed (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
smp_valid  in  1  sample strobe, one sample per cycle when high
smp_data  in  W  sensor sample, unsigned
cfg_wr  in  1  threshold write strobe
cfg_addr  in  3  threshold select (0..4 valid)
cfg_data  in  W  threshold value
zone  out  2  committed zone (00 MID, 10 LOW, 01 HIGH; 11 never driven)
zone_chg  out  1  one-cycle pulse in the cycle zone takes its new value
heat_en  out  1  high iff zone==LOW
cool_en  out  1  high iff zone==HIGH
cfg_err  out  1  one-cycle pulse on a write to addr 5..7

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values:
  - zone=00, zone_chg=0, heat_en=0, cool_en=0, cfg_err=0.
  - cand=00, dwell_cnt=0, hold_cnt=0.
  - Thresholds reload defaults: T0 LO_ENTER=12, T1 HI_ENTER=20, T2 LO2HI=26, T3 HI_EXIT=14, T4 HI2LO=8.
- Target zone, unsigned compares:
  - MID: x<T0 -> LOW; x>T1 -> HIGH; else MID.
  - LOW: T1<x<=T2 -> MID; x>T2 -> HIGH; else LOW.
  - HIGH: T4<=x<T3 -> MID; x<T4 -> LOW; else HIGH.
- Dwell, on edge with smp_valid, no cfg_wr, no commit:
  - target==zone -> dwell_cnt=0.
  - target==cand, target!=zone -> dwell_cnt++, saturating at DWELL.
  - otherwise -> cand=target, dwell_cnt=1.
- Commit condition, from registered values: dwell_cnt==DWELL and cand!=zone and hold_cnt==0.
  - On that edge: zone=cand, zone_chg=1, heat_en/cool_en updated, hold_cnt=MIN_HOLD, dwell_cnt=0.
  - A sample presented in the commit cycle is discarded.
- Latency: zone changes on the edge after the edge that registered the DWELL-th qualifying sample. With hold_cnt==0 this is 2 cycles from the final sample's cycle.
- Hold:
  - hold_cnt decrements each cycle while nonzero.
  - Samples continue updating cand/dwell during hold.
  - A saturated dwell commits on the first edge with hold_cnt==0.
  - A sample whose target==zone during hold cancels the pending change.
- Config:
  - cfg_wr with addr 0..4 writes Tn at the edge; the new value is used from the next cycle.
  - Any cfg_wr (valid or not) clears dwell_cnt; a same-cycle sample is discarded.
  - Addr 5..7: no write, cfg_err=1 for one cycle.
  - cfg_wr takes priority over commit; a commit blocked this way re-evaluates next cycle (dwell now 0, so no commit).
  - Threshold ordering is not checked.
- Reset mid-operation: all state returns to reset values on that edge regardless of other inputs.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package zone_pkg:
  - Zone encodings ZONE_MID/ZONE_LOW/ZONE_HIGH.
  - Threshold defaults T0..T4 and their cfg address constants.
- Sub-module zone_target: combinational (zone, x, T0..T4) -> target zone. Reused by the verification model.

Test Plan:
1. Reset; smp 27,27 on consecutive cycles -> zone 00->01 two cycles after second sample; zone_chg one pulse; cool_en=1, heat_en=0.
2. From MID: smp 3,15,3,3 -> no change after 15 (dwell cleared); zone=10, heat_en=1 two cycles after the 4th sample.
3. Hold: enter HIGH, then smp 5,5 immediately -> zone stays 01 until hold_cnt reaches 0 (MIN_HOLD=4); commits to 10 on the next edge. Repeat with 5,5,20 -> no commit; zone stays 01.
4. Config: write addr1=24; from MID smp 22,22 -> zone stays 00; smp 25,25 -> zone 01.
5. cfg_wr addr6 data 3 -> cfg_err one pulse; defaults unchanged (smp 11,11 from MID still gives LOW). cfg_wr in the same cycle as a qualifying sample -> that sample not counted.
6. Reset mid-dwell: from MID smp 3 (dwell=1, cand LOW); rst_n low one cycle; smp 3 once -> zone stays 00; second 3 -> LOW.

Source files
------------

// File: rtl/zone_pkg.sv
// Shared zone encodings, threshold defaults and config addresses for the zone hysteresis controller.
package zone_pkg;

  typedef enum logic [1:0] {
    ZONE_MID  = 2'b00,
    ZONE_HIGH = 2'b01,
    ZONE_LOW  = 2'b10
  } zone_e;

  localparam int unsigned NUM_THR = 5;

  localparam int unsigned T0_DEF = 12;  // LO_ENTER
  localparam int unsigned T1_DEF = 20;  // HI_ENTER
  localparam int unsigned T2_DEF = 26;  // LO2HI
  localparam int unsigned T3_DEF = 14;  // HI_EXIT
  localparam int unsigned T4_DEF = 8;   // HI2LO

  localparam logic [2:0] ADDR_LO_ENTER = 3'd0;
  localparam logic [2:0] ADDR_HI_ENTER = 3'd1;
  localparam logic [2:0] ADDR_LO2HI    = 3'd2;
  localparam logic [2:0] ADDR_HI_EXIT  = 3'd3;
  localparam logic [2:0] ADDR_HI2LO    = 3'd4;

endpackage

// File: rtl/zone_target.sv
// Combinational target-zone classifier: hysteresis rules applied to one sample from the current zone.
module zone_target
  import zone_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [1:0]   zone,
  input  logic [W-1:0] x,
  input  logic [W-1:0] t0,
  input  logic [W-1:0] t1,
  input  logic [W-1:0] t2,
  input  logic [W-1:0] t3,
  input  logic [W-1:0] t4,
  output logic [1:0]   target_c
);

  always_comb begin
    target_c = zone;
    case (zone)
      ZONE_MID: begin
        if (x < t0)      target_c = ZONE_LOW;
        else if (x > t1) target_c = ZONE_HIGH;
      end
      ZONE_LOW: begin
        if (x > t2)      target_c = ZONE_HIGH;
        else if (x > t1) target_c = ZONE_MID;
      end
      ZONE_HIGH: begin
        if (x < t4)      target_c = ZONE_LOW;
        else if (x < t3) target_c = ZONE_MID;
      end
      default: target_c = ZONE_MID;
    endcase
  end

endmodule

// File: rtl/zone_hyst_ctrl.sv
// Zone controller: programmable thresholds, dwell qualification and post-commit hold,
// driving heater/cooler enables from the committed zone.
module zone_hyst_ctrl
  import zone_pkg::*;
#(
  parameter int unsigned W        = 5,
  parameter int unsigned DWELL    = 2,
  parameter int unsigned MIN_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         smp_valid,
  input  logic [W-1:0] smp_data,
  input  logic         cfg_wr,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  output logic [1:0]   zone,
  output logic         zone_chg,
  output logic         heat_en,
  output logic         cool_en,
  output logic         cfg_err
);

  localparam int unsigned CW = 4;

  logic [1:0]   cand;
  logic [CW-1:0] dwell_cnt;
  logic [CW-1:0] hold_cnt;
  logic [W-1:0] thr [NUM_THR];
  logic [1:0]   target_c;
  logic         commit_c;

  zone_target #(.W(W)) u_target (
    .zone     (zone),
    .x        (smp_data),
    .t0       (thr[0]),
    .t1       (thr[1]),
    .t2       (thr[2]),
    .t3       (thr[3]),
    .t4       (thr[4]),
    .target_c (target_c)
  );

  assign commit_c = (dwell_cnt == CW'(DWELL)) && (cand != zone) && (hold_cnt == '0);

  // Priority per edge: config write, then commit, then sample qualification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zone      <= ZONE_MID;
      zone_chg  <= 1'b0;
      heat_en   <= 1'b0;
      cool_en   <= 1'b0;
      cfg_err   <= 1'b0;
      cand      <= ZONE_MID;
      dwell_cnt <= '0;
      hold_cnt  <= '0;
      thr[0]    <= W'(T0_DEF);
      thr[1]    <= W'(T1_DEF);
      thr[2]    <= W'(T2_DEF);
      thr[3]    <= W'(T3_DEF);
      thr[4]    <= W'(T4_DEF);
    end else begin
      zone_chg <= 1'b0;
      cfg_err  <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);

      if (cfg_wr) begin
        dwell_cnt <= '0;
        case (cfg_addr)
          ADDR_LO_ENTER: thr[0] <= cfg_data;
          ADDR_HI_ENTER: thr[1] <= cfg_data;
          ADDR_LO2HI:    thr[2] <= cfg_data;
          ADDR_HI_EXIT:  thr[3] <= cfg_data;
          ADDR_HI2LO:    thr[4] <= cfg_data;
          default:       cfg_err <= 1'b1;
        endcase
      end else if (commit_c) begin
        zone      <= cand;
        zone_chg  <= 1'b1;
        heat_en   <= (cand == ZONE_LOW);
        cool_en   <= (cand == ZONE_HIGH);
        hold_cnt  <= CW'(MIN_HOLD);
        dwell_cnt <= '0;
      end else if (smp_valid) begin
        if (target_c == zone) begin
          dwell_cnt <= '0;
        end else if (target_c == cand) begin
          if (dwell_cnt != CW'(DWELL)) dwell_cnt <= dwell_cnt + CW'(1);
        end else begin
          cand      <= target_c;
          dwell_cnt <= CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_zone_hyst_ctrl.sv
// Bench for zone_hyst_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_zone_hyst_ctrl;

  localparam int DWELL    = 2;
  localparam int MIN_HOLD = 4;

  localparam logic [1:0] Z_MID  = 2'b00;
  localparam logic [1:0] Z_LOW  = 2'b10;
  localparam logic [1:0] Z_HIGH = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       smp_valid = 1'b0;
  logic [4:0] smp_data = '0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [4:0] cfg_data = '0;
  logic [1:0] zone;
  logic       zone_chg, heat_en, cool_en, cfg_err;

  zone_hyst_ctrl #(.W(5), .DWELL(DWELL), .MIN_HOLD(MIN_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .zone      (zone),
    .zone_chg  (zone_chg),
    .heat_en   (heat_en),
    .cool_en   (cool_en),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: committed zone, pending candidate, run length of agreeing samples, cycles left in hold.
  logic [1:0] m_zone, m_pend;
  int         m_run, m_hold;
  int         m_thr [5];
  logic       m_chg, m_err;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_target(input logic [1:0] z, input int x);
    if (z == Z_MID) begin
      if (x < m_thr[0]) return Z_LOW;
      if (x > m_thr[1]) return Z_HIGH;
      return Z_MID;
    end else if (z == Z_LOW) begin
      if (x > m_thr[2]) return Z_HIGH;
      if (x > m_thr[1] && x <= m_thr[2]) return Z_MID;
      return Z_LOW;
    end else begin
      if (x < m_thr[4]) return Z_LOW;
      if (x >= m_thr[4] && x < m_thr[3]) return Z_MID;
      return Z_HIGH;
    end
  endfunction

  task automatic model_step(input logic v, input int d, input logic w, input int a,
                            input int wd, input logic r);
    logic [1:0] t;
    int         hold_next;
    if (!r) begin
      m_zone = Z_MID; m_pend = Z_MID; m_run = 0; m_hold = 0;
      m_chg = 0; m_err = 0;
      m_thr[0] = 12; m_thr[1] = 20; m_thr[2] = 26; m_thr[3] = 14; m_thr[4] = 8;
      return;
    end
    m_chg = 0;
    m_err = 0;
    hold_next = (m_hold > 0) ? m_hold - 1 : 0;
    if (w) begin
      if (a < 5) m_thr[a] = wd;
      else m_err = 1;
      m_run = 0;
    end else if (m_run >= DWELL && m_pend != m_zone && m_hold == 0) begin
      m_zone = m_pend;
      m_chg = 1;
      hold_next = MIN_HOLD;
      m_run = 0;
    end else if (v) begin
      t = ref_target(m_zone, d);
      if (t == m_zone) m_run = 0;
      else if (t == m_pend) m_run++;
      else begin
        m_pend = t;
        m_run = 1;
      end
    end
    m_hold = hold_next;
  endtask

  task automatic step(input logic v, input int d, input logic w, input int a,
                      input int wd, input logic r);
    smp_valid = v; smp_data = 5'(d);
    cfg_wr = w; cfg_addr = 3'(a); cfg_data = 5'(wd);
    rst_n = r;
    @(posedge clk);
    model_step(v, d, w, a, wd, r);
    #1;
    chk("zone", 8'(zone), 8'(m_zone));
    chk("zone_chg", 8'(zone_chg), 8'(m_chg));
    chk("heat_en", 8'(heat_en), 8'(m_zone == Z_LOW));
    chk("cool_en", 8'(cool_en), 8'(m_zone == Z_HIGH));
    chk("cfg_err", 8'(cfg_err), 8'(m_err));
  endtask

  task automatic smp(input int d);          step(1'b1, d, 1'b0, 0, 0, 1'b1); endtask
  task automatic idle();                    step(1'b0, 0, 1'b0, 0, 0, 1'b1); endtask
  task automatic cfg(input int a, input int wd); step(1'b0, 0, 1'b1, a, wd, 1'b1); endtask
  task automatic do_reset();                step(1'b0, 0, 1'b0, 0, 0, 1'b0); endtask
  task automatic idle_n(input int n); for (int i = 0; i < n; i++) idle(); endtask

  initial begin
    int last_d;
    logic v, w, r;
    int a, wd, d;

    do_reset(); do_reset();
    chk("rst_zone", 8'(zone), 8'(Z_MID));

    // Two high samples commit HIGH two cycles after the second.
    smp(27); smp(27);
    chk("t1_pre_zone", 8'(zone), 8'(Z_MID));
    idle();
    chk("t1_zone", 8'(zone), 8'(Z_HIGH));
    chk("t1_chg", 8'(zone_chg), 8'd1);
    chk("t1_cool", 8'(cool_en), 8'd1);
    idle();
    chk("t1_chg_drop", 8'(zone_chg), 8'd0);

    // An in-band sample breaks the run.
    do_reset();
    smp(3); smp(15); smp(3); smp(3); idle();
    chk("t2_zone", 8'(zone), 8'(Z_LOW));
    chk("t2_heat", 8'(heat_en), 8'd1);

    // Pending change waits out the hold, then commits.
    do_reset();
    smp(27); smp(27); idle(); smp(5); smp(5);
    idle_n(2);
    chk("t3_held", 8'(zone), 8'(Z_HIGH));
    idle_n(4);
    chk("t3_zone", 8'(zone), 8'(Z_LOW));
    do_reset();
    smp(27); smp(27); idle(); smp(5); smp(5); smp(20);
    idle_n(8);
    chk("t3_cancel", 8'(zone), 8'(Z_HIGH));

    // Reprogrammed HI_ENTER.
    do_reset();
    cfg(1, 24);
    smp(22); smp(22); idle_n(2);
    chk("t4_mid", 8'(zone), 8'(Z_MID));
    smp(25); smp(25); idle();
    chk("t4_high", 8'(zone), 8'(Z_HIGH));

    // Bad address flags an error and leaves thresholds alone.
    do_reset();
    cfg(6, 3);
    chk("t5_err", 8'(cfg_err), 8'd1);
    idle();
    chk("t5_err_drop", 8'(cfg_err), 8'd0);
    smp(11); smp(11); idle();
    chk("t5_low", 8'(zone), 8'(Z_LOW));
    do_reset();
    smp(3);
    step(1'b1, 3, 1'b1, 0, 12, 1'b1);
    smp(3); idle_n(2);
    chk("t5_discard", 8'(zone), 8'(Z_MID));

    // Reset in the middle of a dwell.
    do_reset();
    smp(3); do_reset(); smp(3); idle_n(2);
    chk("t6_stay", 8'(zone), 8'(Z_MID));
    smp(3); idle();
    chk("t6_low", 8'(zone), 8'(Z_LOW));

    // Random traffic with sticky samples so dwells complete.
    last_d = 16;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      w = ($urandom_range(0, 19) == 0);
      a = $urandom_range(0, 7);
      case (a)
        0: wd = $urandom_range(8, 14);
        1: wd = $urandom_range(16, 22);
        2: wd = $urandom_range(24, 30);
        3: wd = $urandom_range(12, 16);
        4: wd = $urandom_range(4, 10);
        default: wd = $urandom_range(0, 31);
      endcase
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) < 7) ? last_d : $urandom_range(0, 31);
      last_d = d;
      step(v, d, w, a, wd, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
